// File: rtl/adc_capture_pkg.sv
// Shared widths and FSM state encoding for the ADC capture block.
package adc_capture_pkg;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_capture_if.sv
// Sample stream, trigger control, status and display read port of adc_capture.
interface adc_capture_if #(
  parameter int DATA_W = adc_capture_pkg::DEF_DATA_W,
  parameter int ADDR_W = adc_capture_pkg::DEF_ADDR_W
);

  logic              enable;
  logic [DATA_W-1:0] adc_data;
  logic              arm;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output enable, adc_data, arm, force_trig, trig_level, rd_addr,
    input  busy, done, wr_count, rd_data
  );

  modport slave (
    input  enable, adc_data, arm, force_trig, trig_level, rd_addr,
    output busy, done, wr_count, rd_data
  );

endinterface

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read-before-write read port.
module capture_ram #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_capture.sv
// Triggered one-shot capture of 1024 ADC samples into a buffer read back by the display.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic          clk_adc,
  input logic          reset_n,
  adc_capture_if.slave bus
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_FILL = (ADDR_W + 1)'(DEPTH - 1);

  cap_state_e        state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              level_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  assign level_hit = prev_valid_q && (prev_q < bus.trig_level) &&
                     (bus.adc_data >= bus.trig_level);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_count_d   = wr_count_q;
    wr_en        = 1'b0;
    wr_addr      = '0;

    // arm wins over any trigger or final write in the same cycle
    if (bus.arm) begin
      state_d      = WAIT_TRIG;
      prev_valid_d = 1'b0;
      wr_count_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_TRIG: begin
          if (bus.enable) begin
            prev_d       = bus.adc_data;
            prev_valid_d = 1'b1;
            if (level_hit || bus.force_trig) begin
              wr_en      = 1'b1;
              wr_addr    = '0;
              wr_count_d = (ADDR_W + 1)'(1);
              state_d    = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (bus.enable) begin
            wr_en      = 1'b1;
            wr_addr    = wr_count_q[ADDR_W-1:0];
            wr_count_d = wr_count_q + 1'b1;
            if (wr_count_q == LAST_FILL) begin
              state_d = DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == WAIT_TRIG) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_count_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_count_q   <= wr_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_adc),
    .rst_n   (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.adc_data),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture; read data is checked by a queue-based scoreboard monitor.
module tb_adc_capture;
  import adc_capture_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;

  logic clk_adc = 1'b0;
  logic reset_n = 1'b0;

  adc_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  adc_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_adc (clk_adc),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk_adc = ~clk_adc;

  int assertCount = 0;
  int failCount   = 0;

  logic [DW-1:0] expQ[$];
  logic [DW-1:0] expHead;
  logic          rdIssue     = 1'b0;
  logic          rdValidPipe = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input logic expBusy, input logic expDone,
                             input int expCount);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'(expBusy));
    checkOutput({tag, " done"}, 32'(bus.done), 32'(expDone));
    checkOutput({tag, " wr_count"}, 32'(bus.wr_count), 32'(expCount));
  endtask

  // One clock of stimulus; control strobes and the read request last exactly one cycle.
  task automatic applyStimulus(input logic en, input logic [DW-1:0] data,
                               input logic armV, input logic forceV);
    bus.enable     = en;
    bus.adc_data   = data;
    bus.arm        = armV;
    bus.force_trig = forceV;
    @(posedge clk_adc);
    #1;
    bus.enable     = 1'b0;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    rdIssue        = 1'b0;
  endtask

  task automatic issueRead(input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    bus.rd_addr = addr;
    rdIssue     = 1'b1;
    expQ.push_back(expected);
  endtask

  function automatic logic [DW-1:0] rampA(input int k);
    return DW'(8200 + 100 * k);
  endfunction

  always @(posedge clk_adc) rdValidPipe <= rdIssue;

  // Scoreboard monitor: rd_data is valid one cycle after each issued read.
  always @(negedge clk_adc) begin
    if (rdValidPipe) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL rd_data: got %0d, expected nothing queued", bus.rd_data);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("rd_data", 32'(bus.rd_data), 32'(expHead));
      end
    end
  end

  initial begin
    bus.enable     = 1'b0;
    bus.adc_data   = '0;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    bus.trig_level = DW'(8192);
    bus.rd_addr    = '0;

    repeat (2) @(posedge clk_adc);
    #1;
    checkStatus("reset", 1'b0, 1'b0, 0);
    checkOutput("reset rd_data", 32'(bus.rd_data), 32'd0);
    reset_n = 1'b1;

    applyStimulus(1'b1, DW'(9000), 1'b0, 1'b1);
    applyStimulus(1'b1, DW'(8000), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(8300), 1'b0, 1'b0);
    checkStatus("idle ignores triggers", 1'b0, 1'b0, 0);

    // Level trigger on a rising ramp
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkStatus("arm", 1'b1, 1'b0, 0);
    applyStimulus(1'b1, DW'(8000), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(8100), 1'b0, 1'b0);
    checkStatus("pre-trigger", 1'b1, 1'b0, 0);
    applyStimulus(1'b1, DW'(8200), 1'b0, 1'b0);
    checkStatus("level trigger", 1'b1, 1'b0, 1);
    for (int k = 1; k < 1023; k++) applyStimulus(1'b1, rampA(k), 1'b0, 1'b0);
    checkStatus("before last write", 1'b1, 1'b0, 1023);
    applyStimulus(1'b1, rampA(1023), 1'b0, 1'b0);
    checkStatus("done", 1'b0, 1'b1, 1024);
    applyStimulus(1'b1, DW'(1), 1'b0, 1'b0);
    checkStatus("frozen", 1'b0, 1'b1, 1024);
    issueRead(AW'(0), DW'(8200));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    issueRead(AW'(1), DW'(8300));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Level trigger with enable gaps carrying bogus data
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, DW'(8000), 1'b0, 1'b0);
    applyStimulus(1'b0, DW'(16383), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(8100), 1'b0, 1'b0);
    applyStimulus(1'b0, DW'(16383), 1'b0, 1'b0);
    checkStatus("gap pre-trigger", 1'b1, 1'b0, 0);
    applyStimulus(1'b1, DW'(8200), 1'b0, 1'b0);
    checkStatus("gap trigger", 1'b1, 1'b0, 1);
    for (int k = 1; k < 1023; k++) begin
      applyStimulus(1'b0, DW'(16383), 1'b0, 1'b0);
      applyStimulus(1'b1, rampA(k), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, DW'(16383), 1'b0, 1'b0);
    checkStatus("gap cycle 2046", 1'b1, 1'b0, 1023);
    applyStimulus(1'b1, rampA(1023), 1'b0, 1'b0);
    checkStatus("gap cycle 2047", 1'b0, 1'b1, 1024);
    issueRead(AW'(1), rampA(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    issueRead(AW'(2), rampA(2));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Arm guard: constant input above level never crosses; force_trig captures
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, DW'(9000), 1'b0, 1'b0);
    checkStatus("no crossing", 1'b1, 1'b0, 0);
    applyStimulus(1'b1, DW'(1234), 1'b0, 1'b1);
    checkStatus("force trigger", 1'b1, 1'b0, 1);
    for (int k = 1; k < 1023; k++) applyStimulus(1'b1, DW'(2000 + k), 1'b0, 1'b0);
    checkStatus("force before last", 1'b1, 1'b0, 1023);
    applyStimulus(1'b1, DW'(7777), 1'b1, 1'b0);
    checkStatus("arm beats final write", 1'b1, 1'b0, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkStatus("no done after re-arm", 1'b1, 1'b0, 0);
    issueRead(AW'(0), DW'(1234));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    issueRead(AW'(1022), DW'(3022));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    issueRead(AW'(1023), rampA(1023));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // trig_level 0 can never level-trigger; force with enable low is ignored
    bus.trig_level = '0;
    applyStimulus(1'b1, DW'(0), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(5), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(100), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(16383), 1'b0, 1'b0);
    applyStimulus(1'b0, DW'(77), 1'b0, 1'b1);
    checkStatus("level zero", 1'b1, 1'b0, 0);

    // Known ramp 0..1023 followed by a full readback sweep
    applyStimulus(1'b1, DW'(0), 1'b0, 1'b1);
    for (int k = 1; k < 1024; k++) applyStimulus(1'b1, DW'(k), 1'b0, 1'b0);
    checkStatus("ramp done", 1'b0, 1'b1, 1024);
    for (int a = 0; a < 1024; a++) begin
      issueRead(AW'(a), DW'(a));
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkStatus("arm in done", 1'b1, 1'b0, 0);

    // Read-before-write on address 5
    applyStimulus(1'b1, DW'(5000), 1'b0, 1'b1);
    for (int k = 1; k < 5; k++) applyStimulus(1'b1, DW'(5000 + k), 1'b0, 1'b0);
    issueRead(AW'(5), DW'(5));
    applyStimulus(1'b1, DW'(5005), 1'b0, 1'b0);
    issueRead(AW'(5), DW'(5005));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int k = 6; k < 300; k++) applyStimulus(1'b1, DW'(k), 1'b0, 1'b0);
    checkStatus("mid capture", 1'b1, 1'b0, 300);

    // Asynchronous reset between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    checkStatus("async reset", 1'b0, 1'b0, 0);
    checkOutput("async reset rd_data", 32'(bus.rd_data), 32'd0);
    @(posedge clk_adc);
    #1;
    reset_n = 1'b1;
    issueRead(AW'(0), DW'(5000));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Capture-side counterpart of the DAC sample generator. Takes a 14-bit ADC sample stream and waits for a rising-edge level trigger.
- On trigger, writes exactly 1024 consecutive samples into an internal buffer, then raises done.
- The VGA trace renderer reads the buffer back through a synchronous read port, addressed by its horizontal counter.

Parameters:
- DATA_W, 14, sample width; offset-binary unsigned, same format as the DAC path.
- ADDR_W, 10, buffer address width; depth = 2**ADDR_W = 1024 samples.

Ports:
- clk_adc  input  1  sample clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  sample valid; adc_data is taken only in cycles where enable=1.
- adc_data  input  DATA_W  incoming ADC sample.
- arm  input  1  single-cycle request to start a new acquisition.
- force_trig  input  1  trigger immediately on the next valid sample, ignoring the level.
- trig_level  input  DATA_W  trigger threshold, unsigned.
- busy  output  1  high in the WAIT_TRIG and CAPTURE states.
- done  output  1  high in DONE; cleared by arm or reset.
- wr_count  output  ADDR_W+1  samples written in the current acquisition, 0..1024.
- rd_addr  input  ADDR_W  display read address.
- rd_data  output  DATA_W  buffer word at rd_addr, one-cycle registered latency.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; busy=0, done=0, wr_count=0, rd_data=0.
  - Previous-sample register cleared and prev_valid=0.
  - Buffer contents are not cleared.
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- Arm handling:
  - arm=1 in any state -> WAIT_TRIG next cycle, with wr_count=0, done=0, prev_valid=0.
  - arm has priority over every other event in the same cycle, including a trigger or the final write.
- WAIT_TRIG, on each enable=1 cycle:
  - prev <= adc_data and prev_valid <= 1.
  - Trigger condition is (prev_valid && prev < trig_level && adc_data >= trig_level) || force_trig.
  - Since prev_valid is cleared on arm, a level trigger needs at least two valid samples after arm. force_trig needs only one.
  - On trigger, the triggering sample itself is written to address 0, wr_count becomes 1, and state goes to CAPTURE.
  - enable=0 cycles are ignored entirely; prev is held.
- CAPTURE:
  - Each enable=1 cycle writes adc_data to address wr_count[ADDR_W-1:0] and increments wr_count.
  - The write that makes wr_count=1024 moves the state to DONE in the same edge.
  - No address wrap-around occurs; no write ever happens outside CAPTURE or the trigger cycle.
- DONE:
  - done=1 and busy=0; the buffer is frozen and wr_count holds 1024 until the next arm.
- IDLE: no writes occur; force_trig and level crossings are ignored.
- Trigger comparison is full-width unsigned. trig_level=0 can never level-trigger, because prev<0 is impossible; force_trig is the only way out.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, independent of state.
  - Reading an address in the same cycle it is written returns the old data (read-before-write).
  - Reads during CAPTURE are legal and may return data from the previous acquisition.
- busy and done are registered outputs decoded from state. They are never both 1.

Decomposition:
- Shared package: DATA_W and ADDR_W defaults, plus the state encoding (IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3).
- One sub-module: capture_ram, a simple dual-port RAM (1 write port, 1 registered read port) inferred as a block RAM.
- The FSM, trigger comparator and write counter remain in adc_capture.

Test Plan:
- Reset default: assert reset_n=0 mid-CAPTURE at wr_count=300 -> state=IDLE, busy=0, done=0, wr_count=0 immediately, without waiting for a clock edge.
- Level trigger: trig_level=8192, arm, then feed ramp 8000, 8100, 8200, 8300... -> trigger on 8200; mem[0]=8200, mem[1]=8300.
  - done rises exactly on the 1024th write (1023 valid samples after the trigger); wr_count=1024.
- Sample gaps: repeat the level trigger with enable toggling 1,0,1,0 -> enable=0 cycles are neither compared nor written.
  - Buffer holds 1024 consecutive valid samples; done is reached after 2047 cycles.
- Arm guard and force trigger:
  - arm with a constant input of 9000 and trig_level=8192 -> no trigger, because there is no crossing; busy stays 1.
  - Then pulse force_trig -> the next valid sample goes to address 0.
- Re-arm precedence:
  - arm in the same cycle as the final (1024th) write -> state=WAIT_TRIG, done never asserts, wr_count=0.
  - arm while in DONE -> done clears next cycle.
- Readback: after a capture of a known ramp 0..1023, sweep rd_addr 0..1023 -> rd_data equals the ramp value one cycle after each address.
  - A read of address 5 in the same cycle it is written returns the old content.
